tbus_arbiter: RTL and testbench

Round-robin arbiter for a shared tristate net driven by several tristate-buffer cells (e.g. two `tristate_buffer_one` instances tied to one output bit). Grants the bus to at most one driver at a time and produces the per-driver `enable` lines in the cell convention, where `enable[i]=0` drives and `enable[i]=1` is high-Z. Enforces a bounded ownership time and a guaranteed all-off turnaround between owners, so contention cannot occur by construction.

---
 rtl/tbus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_tbus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tbus_arbiter.sv
// ============================================================================
//  Module      : tbus_arbiter
//  Description : Round-robin owner selection for a shared tristate net with
//                bounded hold time and a mandatory all-off turnaround gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbus_arbiter #(
  parameter int N           = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] enable,
  output logic         bus_idle,
  output logic         hold_expired
);

  localparam int c_PTR_W  = $clog2(N);
  localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int c_TURN_W = $clog2(TURN_CYCLES + 1);

  localparam logic [c_PTR_W-1:0]  c_LAST     = c_PTR_W'(N - 1);
  localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
  localparam logic [c_TURN_W-1:0] c_TURN_MAX = c_TURN_W'(TURN_CYCLES);
  localparam logic [c_TURN_W-1:0] c_TURN_ONE = c_TURN_W'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_GRANT = 2'd1;
  localparam logic [1:0] c_ST_TURN  = 2'd2;

  logic [1:0]          r_state;
  logic [c_PTR_W-1:0]  r_own;
  logic [c_PTR_W-1:0]  r_ptr;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_TURN_W-1:0] r_turn_cnt;
  logic [N-1:0]        r_gnt;
  logic [N-1:0]        r_enable;
  logic                r_bus_idle;
  logic                r_hold_expired;

  logic [1:0]          w_state_nxt;
  logic [c_PTR_W-1:0]  w_own_nxt;
  logic [c_PTR_W-1:0]  w_ptr_nxt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic [c_TURN_W-1:0] w_turn_nxt;
  logic                w_expire_nxt;
  logic [N-1:0]        w_gnt_nxt;

  logic                w_arb_found;
  logic [c_PTR_W-1:0]  w_arb_idx;
  logic                w_own_req;
  logic                w_limit;
  logic                w_do_arb;

  assign w_own_req = req[r_own];
  assign w_limit   = (r_hold_cnt == c_HOLD_MAX);

  // Rotating search starting at r_ptr; wrap is explicit so N need not be 2^k.
  always_comb begin
    int                 w_sum;
    logic [c_PTR_W-1:0] w_idx;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_sum       = 0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_idx = c_PTR_W'(w_sum);
      if (!w_arb_found && req[w_idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_own_nxt    = r_own;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold_cnt;
    w_turn_nxt   = r_turn_cnt;
    w_expire_nxt = 1'b0;
    w_do_arb     = 1'b0;

    case (r_state)
      c_ST_GRANT: begin
        if (!w_own_req || w_limit) begin
          w_state_nxt  = c_ST_TURN;
          w_ptr_nxt    = (r_own == c_LAST) ? '0 : r_own + c_PTR_ONE;
          w_turn_nxt   = c_TURN_ONE;
          // A drop on the limit edge is a voluntary release, not an expiry.
          w_expire_nxt = w_own_req && w_limit;
        end else begin
          w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
        end
      end
      c_ST_TURN: begin
        if (r_turn_cnt == c_TURN_MAX) begin
          w_do_arb = 1'b1;
        end else begin
          w_turn_nxt = r_turn_cnt + c_TURN_ONE;
        end
      end
      default: begin
        w_do_arb = 1'b1;
      end
    endcase

    if (w_do_arb) begin
      if (w_arb_found) begin
        w_state_nxt = c_ST_GRANT;
        w_own_nxt   = w_arb_idx;
        w_hold_nxt  = c_HOLD_ONE;
      end else begin
        w_state_nxt = c_ST_IDLE;
      end
    end
  end

  // Outputs are derived from the next state so they can be registered.
  always_comb begin
    w_gnt_nxt = '0;
    if (w_state_nxt == c_ST_GRANT) begin
      w_gnt_nxt[w_own_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_ST_IDLE;
      r_own          <= '0;
      r_ptr          <= '0;
      r_hold_cnt     <= '0;
      r_turn_cnt     <= '0;
      r_gnt          <= '0;
      r_enable       <= '1;
      r_bus_idle     <= 1'b1;
      r_hold_expired <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_own          <= w_own_nxt;
      r_ptr          <= w_ptr_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_turn_cnt     <= w_turn_nxt;
      r_gnt          <= w_gnt_nxt;
      r_enable       <= ~w_gnt_nxt;
      r_bus_idle     <= (w_gnt_nxt == '0);
      r_hold_expired <= w_expire_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign enable       = r_enable;
  assign bus_idle     = r_bus_idle;
  assign hold_expired = r_hold_expired;

endmodule

`default_nettype wire

// File: tb/tb_tbus_arbiter.sv
// ============================================================================
//  Module      : tb_tbus_arbiter
//  Description : Scoreboard bench for tbus_arbiter (two parameter sets).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tbus_arbiter;

  localparam int c_N       = 4;
  localparam int c_MH      = 4;
  localparam int c_TC_A    = 1;
  localparam int c_TC_B    = 2;
  localparam int c_BOUND_A = (c_N - 1) * (c_MH + c_TC_A) + c_TC_A + 1;
  localparam int c_BOUND_B = (c_N - 1) * (c_MH + c_TC_B) + c_TC_B + 1;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] req_a = 4'b0;
  logic [3:0] req_b = 4'b0;
  logic [3:0] gnt_a, en_a, gnt_b, en_b;
  logic       idle_a, idle_b, he_a, he_b;

  typedef struct {
    string      nm;
    logic [3:0] ga;
    logic       ha;
    logic [3:0] gb;
    logic       hb;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  string phase = "reset";

  logic [3:0] prev_g [2] = '{4'b0, 4'b0};
  int         off_run [2] = '{1000, 1000};
  int         on_run [2] = '{0, 0};
  int         wait_c [2][4];

  tbus_arbiter #(.N(c_N), .MAX_HOLD(c_MH), .TURN_CYCLES(c_TC_A)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .enable(en_a),
    .bus_idle(idle_a), .hold_expired(he_a)
  );

  tbus_arbiter #(.N(c_N), .MAX_HOLD(c_MH), .TURN_CYCLES(c_TC_B)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .enable(en_b),
    .bus_idle(idle_b), .hold_expired(he_b)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] ga, input logic ha,
                      input logic [3:0] gb, input logic hb);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req_a = ra;
    req_b = rb;
    e.nm = phase;
    e.ga = ga;
    e.ha = ha;
    e.gb = gb;
    e.hb = hb;
    q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [3:0] g, input logic [3:0] en,
                     input logic idl, input logic he,
                     input logic [3:0] eg, input logic eh);
    logic [3:0] w_en_exp;
    logic       w_idle_exp;
    w_en_exp   = ~eg;
    w_idle_exp = (eg == 4'b0);
    n_vec++;
    if (g !== eg || en !== w_en_exp || idl !== w_idle_exp || he !== eh) begin
      n_fail++;
      $display("FAIL %s t=%0t: got gnt=%b enable=%b bus_idle=%b hold_expired=%b, want gnt=%b enable=%b bus_idle=%b hold_expired=%b",
               tag, $time, g, en, idl, he, eg, w_en_exp, w_idle_exp, eh);
    end
  endtask

  task automatic chk(input bit ok, input string nm, input int act, input int want);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, want);
    end
  endtask

  // Protocol invariants that must hold every cycle for either instance.
  task automatic inv(input int d, input logic r, input logic [3:0] g,
                     input logic [3:0] en, input logic [3:0] rq, input logic idl,
                     input int tc, input int bound);
    logic [3:0] w_ng;
    w_ng = ~g;
    if (r) begin
      chk(g == 4'b0, "rst_gnt", int'(g), 0);
      prev_g[d]  = 4'b0;
      off_run[d] = 1000;
      on_run[d]  = 0;
      for (int i = 0; i < 4; i++) wait_c[d][i] = 0;
    end else begin
      chk($countones(~en) <= 1, "one_driver", $countones(~en), 1);
      chk(en == w_ng, "enable_vs_gnt", int'(en), int'(w_ng));
      chk(idl == (g == 4'b0), "bus_idle", int'(idl), int'(g == 4'b0));
      if (g != 4'b0) begin
        if (prev_g[d] != 4'b0) begin
          chk(g == prev_g[d], "no_direct_switch", int'(g), int'(prev_g[d]));
          on_run[d]++;
        end else begin
          chk(off_run[d] >= tc, "turn_gap", off_run[d], tc);
          on_run[d] = 1;
        end
        chk(on_run[d] <= c_MH, "max_hold", on_run[d], c_MH);
        off_run[d] = 0;
      end else begin
        off_run[d]++;
        on_run[d] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && !g[i]) wait_c[d][i]++;
        else wait_c[d][i] = 0;
        chk(wait_c[d][i] <= bound, "wait_bound", wait_c[d][i], bound);
      end
      prev_g[d] = g;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp({e.nm, "_a"}, gnt_a, en_a, idle_a, he_a, e.ga, e.ha);
      cmp({e.nm, "_b"}, gnt_b, en_b, idle_b, he_b, e.gb, e.hb);
    end
    inv(0, rst, gnt_a, en_a, req_a, idle_a, c_TC_A, c_BOUND_A);
    inv(1, rst, gnt_b, en_b, req_b, idle_b, c_TC_B, c_BOUND_B);
  end

  initial begin
    int         pa, pb;
    logic [3:0] ga, gb;
    logic       ha, hb;

    // Reset with all requests high, then first grant to driver 0.
    phase = "reset_idle";
    step(1, 4'b1111, 4'b1111, 4'b0, 1'b0, 4'b0, 1'b0);
    step(1, 4'b1111, 4'b1111, 4'b0, 1'b0, 4'b0, 1'b0);
    step(0, 4'b1111, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b0);
    step(0, 4'b1111, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b0);

    // A: two contenders hit the hold limit; B: sole requester with 2-cycle gap.
    phase = "forced_release";
    step(1, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      pa = (c - 1) % 10;
      pb = (c - 1) % 6;
      if (pa < 4)       begin ga = 4'b0001; ha = 1'b0; end
      else if (pa == 4) begin ga = 4'b0000; ha = 1'b1; end
      else if (pa < 9)  begin ga = 4'b0010; ha = 1'b0; end
      else              begin ga = 4'b0000; ha = 1'b1; end
      if (pb < 4)       begin gb = 4'b0100; hb = 1'b0; end
      else if (pb == 4) begin gb = 4'b0000; hb = 1'b1; end
      else              begin gb = 4'b0000; hb = 1'b0; end
      step(0, 4'b0011, 4'b0100, ga, ha, gb, hb);
    end

    // Pointer parked at 3, then a short voluntary grant wraps it to 0.
    phase = "wrap";
    step(1, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0100, 4'b0, 4'b0100, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b1000, 4'b0, 4'b1000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b1000, 4'b0, 4'b1000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    repeat (4) step(0, 4'b1001, 4'b0, 4'b0001, 1'b0, 4'b0, 1'b0);
    step(0, 4'b1001, 4'b0, 4'b0000, 1'b1, 4'b0, 1'b0);
    repeat (4) step(0, 4'b1001, 4'b0, 4'b1000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b1001, 4'b0, 4'b0000, 1'b1, 4'b0, 1'b0);
    step(0, 4'b1001, 4'b0, 4'b0001, 1'b0, 4'b0, 1'b0);

    // Drop on the limit edge (no pulse), then reset in the 3rd granted cycle.
    phase = "mid_reset";
    step(1, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    repeat (4) step(0, 4'b0001, 4'b0, 4'b0001, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0000, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    repeat (3) step(0, 4'b0100, 4'b0, 4'b0100, 1'b0, 4'b0, 1'b0);
    step(1, 4'b0100, 4'b0, 4'b0000, 1'b0, 4'b0, 1'b0);
    step(0, 4'b0011, 4'b0, 4'b0001, 1'b0, 4'b0, 1'b0);

    // Random requests; a waiting requester keeps its request up.
    phase = "stress";
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!(req_a[i] && !gnt_a[i])) req_a[i] = 1'($urandom_range(0, 1));
        if (!(req_b[i] && !gnt_b[i])) req_b[i] = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    req_a = 4'b0;
    req_b = 4'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
